// File: rtl/gcd_pkg.sv
// Shared types and constants for the gcd front-end sequencer.
package gcd_pkg;

    localparam int GCD_W     = 32;
    localparam int CYC_W     = 8;
    localparam int TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

    // Tag is stored zero-extended to TAG_MAX_W; the top slices its own width back out.
    typedef struct packed {
        logic [GCD_W-1:0]     result;
        logic [TAG_MAX_W-1:0] tag;
        logic [CYC_W-1:0]     cyc;
        logic                 err;
    } out_rec_t;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        if (v == {CYC_W{1'b1}}) begin
            return v;
        end else begin
            return v + CYC_W'(1);
        end
    endfunction

endpackage

// File: rtl/gcd_fifo.sv
// Synchronous FIFO holding tagged operand pairs; power-of-two depth, async reset.
module gcd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 68
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + CW'(1);
        end else if (!do_push_s && do_pop_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din;
            end
        end
    end

endmodule

// File: rtl/gcd_dispatch.sv
// Front-end sequencer: buffers tagged operand pairs, issues them to an external gcd
// datapath one at a time, and returns result/tag/iteration count/error on an output stream.
module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int MAX_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [GCD_W-1:0] in_opa,
    input  logic [GCD_W-1:0] in_opb,
    input  logic [TAG_W-1:0] in_tag,
    output logic [GCD_W-1:0] gcd_opa,
    output logic [GCD_W-1:0] gcd_opb,
    output logic             gcd_start,
    output logic             gcd_resetn,
    input  logic [GCD_W-1:0] gcd_result,
    input  logic             gcd_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [GCD_W-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [CYC_W-1:0] out_cyc,
    output logic             out_err
);

    localparam int FW = 2 * GCD_W + TAG_W;

    logic [FW-1:0]    fifo_din_s, fifo_dout_s;
    logic             fifo_full_s, fifo_empty_s;
    logic             push_s, pop_s;
    logic [GCD_W-1:0] head_opa_s, head_opb_s;
    logic [TAG_W-1:0] head_tag_s;

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic [GCD_W-1:0] gcd_opa_q, gcd_opa_d;
    logic [GCD_W-1:0] gcd_opb_q, gcd_opb_d;
    logic             gcd_start_q, gcd_start_d;
    logic             gcd_resetn_q, gcd_resetn_d;
    logic             out_valid_q, out_valid_d;
    out_rec_t         out_q, out_d;
    out_rec_t         rec_s;
    logic             cap_ok_s, capture_s, cnt_at_max_s;
    logic             unused_tag_s;

    assign fifo_din_s = {in_tag, in_opa, in_opb};
    assign {head_tag_s, head_opa_s, head_opb_s} = fifo_dout_s;
    assign push_s     = in_valid & ~fifo_full_s;
    assign in_ready   = ~fifo_full_s;
    assign cap_ok_s   = ~out_valid_q | out_ready;
    assign cnt_at_max_s = (int'(cnt_q) >= MAX_CYC);

    gcd_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (fifo_din_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; done is only looked at in WAIT since it is stale during ISSUE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s && (head_opb_s != '0)) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (gcd_done) begin
                    if (cap_ok_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (cnt_at_max_s) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ABORT: begin
                if (cap_ok_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ABORT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: operand load, cycle counter, capture record and pop.
    always_comb begin
        capture_s  = 1'b0;
        rec_s      = '0;
        rec_s.tag  = TAG_MAX_W'(head_tag_s);
        cnt_d      = cnt_q;
        gcd_opa_d  = gcd_opa_q;
        gcd_opb_d  = gcd_opb_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_empty_s) begin
                    capture_s = 1'b0;
                end else if (head_opb_s == '0) begin
                    // b=0 would make gcd return 0, so the answer is a and gcd is skipped.
                    capture_s    = cap_ok_s;
                    rec_s.result = head_opa_s;
                end else begin
                    gcd_opa_d = head_opa_s;
                    gcd_opb_d = head_opb_s;
                    cnt_d     = '0;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q;
            end
            ST_WAIT: begin
                if (gcd_done) begin
                    capture_s    = cap_ok_s;
                    rec_s.result = gcd_result;
                    rec_s.cyc    = cnt_q;
                end else if (cnt_at_max_s) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_ABORT: begin
                capture_s = cap_ok_s;
                rec_s.cyc = cnt_q;
                rec_s.err = 1'b1;
            end
            default: begin
                capture_s = 1'b0;
            end
        endcase

        pop_s        = capture_s;
        gcd_start_d  = (state_d == ST_ISSUE);
        gcd_resetn_d = ~((state_d == ST_ABORT) && (state_q != ST_ABORT));

        if (capture_s) begin
            out_valid_d = 1'b1;
            out_d       = rec_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_d       = out_q;
        end else begin
            out_valid_d = out_valid_q;
            out_d       = out_q;
        end
    end

    // Registered outputs to gcd and the output slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            gcd_opa_q    <= '0;
            gcd_opb_q    <= '0;
            gcd_start_q  <= 1'b0;
            gcd_resetn_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            gcd_opa_q    <= gcd_opa_d;
            gcd_opb_q    <= gcd_opb_d;
            gcd_start_q  <= gcd_start_d;
            gcd_resetn_q <= gcd_resetn_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
        end
    end

    assign gcd_opa    = gcd_opa_q;
    assign gcd_opb    = gcd_opb_q;
    assign gcd_start  = gcd_start_q;
    assign gcd_resetn = gcd_resetn_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_q.result;
    assign out_tag    = out_q.tag[TAG_W-1:0];
    assign out_cyc    = out_q.cyc;
    assign out_err    = out_q.err;
    // Upper tag bits are zero-filled and never read.
    assign unused_tag_s = ^out_q.tag;

endmodule

// File: doc/gcd_dispatch.md
# gcd_dispatch

Front-end sequencer for the `gcd` datapath. It accepts tagged operand pairs over a valid/ready stream and buffers them in a small FIFO. It issues each pair to `gcd` with a one-cycle start pulse, waits for `done`, then returns the result, tag, iteration count and error flag on an output valid/ready stream. `gcd` is instantiated beside it at the top level, not inside it.

## Interface
- `DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `TAG_W`, 4: tag width, passed through unchanged.
- `MAX_CYC`, 64: watchdog limit, in WAIT cycles with `gcd_done`=0.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid` / `in_ready`  in / out  1 / 1  input handshake.
- `in_opa`, `in_opb`  in  32 each  operands.
- `in_tag`  in  TAG_W  job tag.
- `gcd_opa`, `gcd_opb`  out  32 each  operands to `gcd`, registered.
- `gcd_start`  out  1  one-cycle start pulse to `gcd`.
- `gcd_resetn`  out  1  active-low reset to `gcd`, registered.
- `gcd_result`  in  32  result from `gcd`.
- `gcd_done`  in  1  done level from `gcd`.
- `out_valid` / `out_ready`  out / in  1 / 1  output handshake.
- `out_result`  out  32  result.
- `out_tag`  out  TAG_W  tag of the job.
- `out_cyc`  out  8  count of WAIT cycles with done low; saturates at 255.
- `out_err`  out  1  1 = watchdog abort; `out_result`=0.

## Operation
- FIFO: `in_ready` = !full. A push occurs on `in_valid & in_ready`. A pop occurs only when the job is captured. No push is accepted while full, even if a pop happens in the same cycle.
- Output slot: one register. A capture is allowed when `!out_valid | out_ready` (drain and refill can occur in the same cycle). `out_valid` holds until `out_ready`.
- FSM states: IDLE, ISSUE, WAIT, ABORT.
  - IDLE, FIFO empty: stay in IDLE.
  - IDLE, head `opb`==0: bypass `gcd`, because `gcd` returns 0 for b=0. If a capture is allowed, capture {result=head `opa`, cyc=0, err=0}, pop, and stay in IDLE. Otherwise stall.
  - IDLE, head `opb`≠0: load `gcd_opa`/`gcd_opb` from the head, clear the counter, go to ISSUE.
  - ISSUE: `gcd_start`=1 for exactly this cycle, then go to WAIT.
  - WAIT, `gcd_done`=0: increment the counter. When the counter reaches MAX_CYC, go to ABORT.
  - WAIT, `gcd_done`=1 and capture allowed: capture {`gcd_result`, counter, err=0}, pop, go to IDLE.
  - WAIT, `gcd_done`=1 and capture not allowed: stay in WAIT. `gcd` holds `done` and the result until its next init.
  - ABORT: drive `gcd_resetn`=0 for one cycle. Capture {0, counter, err=1} and pop when allowed, then go to IDLE.
- `gcd_start` is low for at least one cycle between pulses, which meets the `gcd` edge-detect rule. `done` is never sampled in ISSUE, where it is still stale from the previous job.

## Timing
- Reset values: `in_ready`=1, `gcd_start`=0, `gcd_resetn`=0 (asserted asynchronously with `reset`, released at the first edge after `reset` falls), `gcd_opa`/`gcd_opb`=0, `out_valid`=0, `out_result`=0, `out_tag`=0, `out_cyc`=0, `out_err`=0. FSM in IDLE, FIFO empty.
- Latency, empty FIFO and free output slot, accept at edge E0:
  - ISSUE after E1; `gcd` inits at E2.
  - N WAIT cycles with done low; done is seen in the next cycle.
  - `out_valid`=1 after E(N+3), with `out_cyc`=N.
- Bypass latency: `out_valid` after E1.
- Throughput: one job in flight. The next ISSUE follows capture by ≥1 IDLE cycle.
- Reset mid-job: FIFO, output slot and job in flight are discarded; `gcd` is reset through `gcd_resetn`.

## Structure
- Package `gcd_pkg`: `GCD_W`=32, the FSM state enum, and the output record type {result, tag, cyc, err}.
- Sub-module `gcd_fifo`: synchronous FIFO with parameters DEPTH and width 64+TAG_W, full/empty flags, async reset. Pointers wrap modulo DEPTH; occupancy uses log2(DEPTH)+1 bits.

## Test plan
- (12,8), tag 3, `out_ready`=1 → `out_result`=4, `out_tag`=3, `out_cyc`=2, `out_err`=0; `out_valid` rises 5 edges after accept.
- (48,18) then (0,5) back-to-back → 6 (cyc 3), then 5 (cyc 1), in order; exactly one `gcd_start` pulse per job.
- (7,0) and (0,0) → bypass: 7 and 0, cyc 0, 1-cycle latency, `gcd_start` never pulses.
- `out_ready`=0, push 5 jobs with DEPTH=4 → `in_ready` falls after 4 accepted. The first result holds stable under backpressure. Releasing `out_ready` drains all results in order.
- MAX_CYC=2, (48,18) → `gcd_resetn` pulses low for 1 cycle, `out_err`=1, `out_result`=0, `out_cyc`=2. The next job (12,8) → 4.
- `reset` asserted while in WAIT → all outputs return to reset values immediately, and a fresh job completes correctly after release.
